sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Two-port round-robin arbiter in front of the 32-bit SRAM controller.
- Port A is the instruction fetch side; port B is the data load/store side. Both share the single request/ready SRAM controller.
- Captures the granted port's command and sequences exactly one controller transaction at a time.
- Forces one idle cycle between transactions so the controller's cycle counter returns to 0.

Parameters:
- TIMEOUT, 64: cycles allowed for i_sram_ready before abort. Used only with SRAM_ARBITER_TIMEOUT_EN.
- ERROR_DATA, 32'hDEADBEEF: read data returned on timeout abort.

Ports:
- i_clock  in  1  system clock; all state changes on its rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_pa_request  in  1  port A request, held until o_pa_ready
- i_pa_rw  in  1  port A direction: 1 write, 0 read
- i_pa_address  in  32  port A byte address
- i_pa_wdata  in  32  port A write data
- o_pa_rdata  out  32  port A read data, valid while o_pa_ready=1
- o_pa_ready  out  1  port A completion pulse, 1 cycle
- i_pb_request / i_pb_rw / i_pb_address / i_pb_wdata / o_pb_rdata / o_pb_ready: same as port A, for port B
- o_sram_request  out  1  request to SRAM controller
- o_sram_rw  out  1  direction to controller
- o_sram_address  out  32  address to controller
- o_sram_wdata  out  32  write data to controller
- i_sram_rdata  in  32  read data from controller
- i_sram_ready  in  1  controller completion
- o_error  out  1  sticky timeout flag; constant 0 when the macro is absent

Behaviour:
- States: IDLE, BUSY, RELEASE. Register grant_id (0=A, 1=B) and last_id.
- Reset (async, i_reset_n=0):
  - state=IDLE, last_id=B so A wins the first tie, grant_id=A.
  - All outputs 0, including rdata registers and o_error.
  - o_sram_request drops immediately, mid-transaction included. The aborted requester gets no ready.
- IDLE:
  - If exactly one request is high, grant that port.
  - If both are high, grant the port != last_id.
  - On grant: latch that port's rw/address/wdata into command registers, set grant_id, go BUSY.
  - No request: stay IDLE.
- BUSY:
  - o_sram_request=1; o_sram_rw/address/wdata come from the command registers.
  - Later changes on the port inputs are ignored.
  - On i_sram_ready=1: capture i_sram_rdata into the granted port's rdata register, set last_id=grant_id, go RELEASE.
- RELEASE (exactly 1 cycle):
  - o_sram_request=0.
  - Granted port's o_pX_ready=1 (registered); the other port's ready=0.
  - Go IDLE.
- The ungranted port's rdata holds its previous value.
- Latency: request seen in IDLE at edge N → o_sram_request high from N+1 → ready pulse one cycle after the edge that samples i_sram_ready. Total = controller cycles + 2.
- Requester rule: drop request at the edge that samples o_pX_ready. A request still high in the following IDLE is a new transaction.
- Back-to-back:
  - Both ports continuously requesting alternate A,B,A,B.
  - Minimum gap between controller transactions is 2 cycles of o_sram_request=0 (RELEASE + IDLE).
- Port rw/address values on non-granted ports never reach the controller.
- Outputs to the controller come from registers; no combinational path from port inputs to o_sram_*.

Optional Feature:
- Macro SRAM_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT-1 without i_sram_ready: load ERROR_DATA into the granted rdata, set o_error=1 (sticky until reset), go RELEASE. The ready pulse is issued normally.
  - i_sram_ready in the same cycle as timeout: ready wins, no error.
- Undefined: no counter; BUSY waits indefinitely; o_error tied 0.

Decomposition:
- Shared package sram_arb_pkg:
  - State encoding constants IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2.
  - Port id constants PORT_A=1'b0, PORT_B=1'b1.
  - ERROR_DATA default.
- Sub-module sram_arb_watchdog (counter + expiry flag), instantiated only under the macro.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset, then A read at 0x00000100 with controller returning 0x12345678 → one controller request, o_pa_ready pulse with o_pa_rdata=0x12345678, o_pb_ready never set.
- A and B requesting simultaneously from reset (A write 0xCAFEF00D to 0x40, B read 0x80) → A served first, then B. o_sram_request low for exactly 2 cycles between them. o_sram_wdata=0xCAFEF00D during A.
- Both held continuously for 4 transactions → grant order A,B,A,B; each port receives exactly 2 ready pulses.
- Change i_pa_address from 0x10 to 0x20 mid-BUSY → o_sram_address stays 0x10 until RELEASE.
- Assert i_reset_n=0 mid-BUSY → o_sram_request=0 the same cycle without a clock edge, no ready pulse. After release, a new A request is served normally.
- With SRAM_ARBITER_TIMEOUT_EN and TIMEOUT=64, controller never readies → o_pa_ready after 64 BUSY cycles, o_pa_rdata=0xDEADBEEF, o_error=1 and stays 1 across later good transactions.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM bus arbiter.
// Used by sram_bus_arbiter and sram_arb_watchdog.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEADBEEF;

  // Round-robin pick: a lone requester wins; on a tie the port that was
  // not served last wins.
  function automatic logic pick_port(input logic req_a, input logic req_b,
                                     input logic last_id);
    if (req_a && req_b) return ~last_id;
    return req_b ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sram_arb_watchdog.sv
// Busy-cycle watchdog for the SRAM arbiter: counts cycles spent waiting on the
// controller and flags expiry on the TIMEOUT-th cycle.
module sram_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_busy,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count is 0 in the first BUSY cycle, so LAST is reached on cycle TIMEOUT.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)       count <= '0;
    else if (!i_busy)     count <= '0;
    else if (count != LAST) count <= count + CW'(1);
  end

  assign o_expired = i_busy && (count == LAST);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-port round-robin arbiter sequencing one SRAM controller transaction at a
// time. Define SRAM_ARBITER_TIMEOUT_EN to enable the busy watchdog and o_error.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERROR_DATA = ERROR_DATA_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_pa_request,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_ready,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_ready,
  output logic        o_sram_request,
  output logic        o_sram_rw,
  output logic [31:0] o_sram_address,
  output logic [31:0] o_sram_wdata,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_sram_ready,
  output logic        o_error
);

  state_t      state, next_state;
  logic        grant_id, last_id, grant_pick;
  logic        cmd_rw;
  logic [31:0] cmd_address, cmd_wdata;
  logic [31:0] pa_rdata_q, pb_rdata_q;
  logic        any_request, busy, timeout, finish;
  logic [31:0] finish_data;

  assign any_request = i_pa_request || i_pb_request;
  assign grant_pick  = pick_port(i_pa_request, i_pb_request, last_id);
  assign busy        = (state == BUSY);
  // A controller ready in the expiry cycle wins over the timeout.
  assign finish      = busy && (i_sram_ready || timeout);
  assign finish_data = i_sram_ready ? i_sram_rdata : ERROR_DATA;

`ifdef SRAM_ARBITER_TIMEOUT_EN
  logic expired, error_q;

  sram_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_busy    (busy),
    .o_expired (expired)
  );

  assign timeout = expired && !i_sram_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)             error_q <= 1'b0;
    else if (busy && timeout)   error_q <= 1'b1;
  end

  assign o_error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
  assign o_error        = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;
  end

  // NOTE: next_state takes a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_request) next_state = BUSY;
      BUSY:    if (finish)      next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Controller-facing outputs depend only on registered state and command.
  always_comb begin
    o_sram_request = busy;
    o_sram_rw      = cmd_rw;
    o_sram_address = cmd_address;
    o_sram_wdata   = cmd_wdata;
    o_pa_ready     = (state == RELEASE) && (grant_id == PORT_A);
    o_pb_ready     = (state == RELEASE) && (grant_id == PORT_B);
    o_pa_rdata     = pa_rdata_q;
    o_pb_rdata     = pb_rdata_q;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant_id    <= PORT_A;
      last_id     <= PORT_B;
      cmd_rw      <= 1'b0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
      pa_rdata_q  <= '0;
      pb_rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_request) begin
        grant_id    <= grant_pick;
        cmd_rw      <= (grant_pick == PORT_A) ? i_pa_rw      : i_pb_rw;
        cmd_address <= (grant_pick == PORT_A) ? i_pa_address : i_pb_address;
        cmd_wdata   <= (grant_pick == PORT_A) ? i_pa_wdata   : i_pb_wdata;
      end
      if (finish) begin
        last_id <= grant_id;
        if (grant_id == PORT_A) pa_rdata_q <= finish_data;
        else                    pb_rdata_q <= finish_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: table of single transactions plus
// hand-written back-to-back, address-hold, async-reset and timeout sequences.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_pa_request = 1'b0, i_pa_rw = 1'b0;
  logic [31:0] i_pa_address = '0, i_pa_wdata = '0;
  logic        i_pb_request = 1'b0, i_pb_rw = 1'b0;
  logic [31:0] i_pb_address = '0, i_pb_wdata = '0;
  logic [31:0] i_sram_rdata = '0;
  logic        i_sram_ready = 1'b0;
  logic [31:0] o_pa_rdata, o_pb_rdata, o_sram_address, o_sram_wdata;
  logic        o_pa_ready, o_pb_ready, o_sram_request, o_sram_rw, o_error;

  always #5 clk = ~clk;

  sram_bus_arbiter dut (
    .i_clock        (clk),
    .i_reset_n      (i_reset_n),
    .i_pa_request   (i_pa_request),
    .i_pa_rw        (i_pa_rw),
    .i_pa_address   (i_pa_address),
    .i_pa_wdata     (i_pa_wdata),
    .o_pa_rdata     (o_pa_rdata),
    .o_pa_ready     (o_pa_ready),
    .i_pb_request   (i_pb_request),
    .i_pb_rw        (i_pb_rw),
    .i_pb_address   (i_pb_address),
    .i_pb_wdata     (i_pb_wdata),
    .o_pb_rdata     (o_pb_rdata),
    .o_pb_ready     (o_pb_ready),
    .o_sram_request (o_sram_request),
    .o_sram_rw      (o_sram_rw),
    .o_sram_address (o_sram_address),
    .o_sram_wdata   (o_sram_wdata),
    .i_sram_rdata   (i_sram_rdata),
    .i_sram_ready   (i_sram_ready),
    .o_error        (o_error)
  );

  typedef struct {
    logic        a_req;
    logic        a_rw;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic        b_rw;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    int          lat;
    logic [31:0] ctrl_rdata;
    logic        exp_port;
    logic        exp_rw;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] model_pa_rdata = '0;
  logic [31:0] model_pb_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    i_pa_request = 1'b0;
    i_pb_request = 1'b0;
    i_sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    i_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    model_pa_rdata = '0;
    model_pb_rdata = '0;
  endtask

  // Starts at a negedge with the arbiter in IDLE; ends at the following IDLE negedge.
  task automatic run_vec(input vec_t v, input string tag);
    i_pa_request = v.a_req;  i_pa_rw = v.a_rw;
    i_pa_address = v.a_addr; i_pa_wdata = v.a_wdata;
    i_pb_request = v.b_req;  i_pb_rw = v.b_rw;
    i_pb_address = v.b_addr; i_pb_wdata = v.b_wdata;
    for (int i = 1; i <= v.lat; i++) begin
      @(negedge clk);
      check($sformatf("%s busy req", tag), o_sram_request, 1);
      check($sformatf("%s busy readies", tag), {o_pa_ready, o_pb_ready}, 0);
      if (i == 1) begin
        check($sformatf("%s rw", tag), o_sram_rw, v.exp_rw);
        check($sformatf("%s addr", tag), o_sram_address, v.exp_addr);
        check($sformatf("%s wdata", tag), o_sram_wdata, v.exp_wdata);
      end
      if (i == v.lat) begin
        i_sram_ready = 1'b1;
        i_sram_rdata = v.ctrl_rdata;
      end
    end
    @(negedge clk);
    check($sformatf("%s release req", tag), o_sram_request, 0);
    if (v.exp_port == PORT_A) model_pa_rdata = v.ctrl_rdata;
    else                      model_pb_rdata = v.ctrl_rdata;
    check($sformatf("%s pa_ready", tag), o_pa_ready, v.exp_port == PORT_A);
    check($sformatf("%s pb_ready", tag), o_pb_ready, v.exp_port == PORT_B);
    check($sformatf("%s pa_rdata", tag), o_pa_rdata, model_pa_rdata);
    check($sformatf("%s pb_rdata", tag), o_pb_rdata, model_pb_rdata);
    drop_all();
    @(negedge clk);
    check($sformatf("%s idle req", tag), o_sram_request, 0);
    check($sformatf("%s idle readies", tag), {o_pa_ready, o_pb_ready}, 0);
  endtask

  vec_t vecs[6];
  vec_t fresh;
  int   txn, gap, busy, pa_cnt, pb_cnt;
  logic seen, done;

  initial begin
    // Expected winners follow last_id, which starts at B after reset.
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                3, 32'h1234_5678, PORT_A, 1'b0, 32'h0000_0100, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 32'h55AA_55AA,
                1, 32'h0BAD_F00D, PORT_B, 1'b1, 32'h0000_0200, 32'h55AA_55AA};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0080, 32'h1111_1111,
                2, 32'h0, PORT_A, 1'b1, 32'h0000_0040, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0080, 32'h1111_1111,
                2, 32'h8765_4321, PORT_B, 1'b0, 32'h0000_0080, 32'h1111_1111};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h2222_2222, 1'b1, 1'b1, 32'h0000_0400, 32'h3333_3333,
                1, 32'hA5A5_A5A5, PORT_A, 1'b0, 32'h0000_0300, 32'h2222_2222};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,
                4, 32'hFFFF_FFFF, PORT_B, 1'b0, 32'hFFFF_FFFC, 32'h0};
    fresh   = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                2, 32'h600D_CAFE, PORT_A, 1'b0, 32'h0000_0600, 32'h0};

    // Reset state, sampled while reset is held and before any clock edge.
    #1 i_reset_n = 1'b0;
    #1;
    check("reset sram_request", o_sram_request, 0);
    check("reset sram_rw", o_sram_rw, 0);
    check("reset sram_address", o_sram_address, 0);
    check("reset sram_wdata", o_sram_wdata, 0);
    check("reset readies", {o_pa_ready, o_pb_ready}, 0);
    check("reset pa_rdata", o_pa_rdata, 0);
    check("reset pb_rdata", o_pb_rdata, 0);
    check("reset error", o_error, 0);
    @(negedge clk);
    i_reset_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Both ports held from reset: A,B,A,B with a 2-cycle request gap.
    do_reset();
    i_pa_request = 1'b1; i_pa_rw = 1'b1; i_pa_address = 32'h40; i_pa_wdata = 32'hCAFE_F00D;
    i_pb_request = 1'b1; i_pb_rw = 1'b0; i_pb_address = 32'h80; i_pb_wdata = 32'h0;
    txn = 0; gap = 0; busy = 0; pa_cnt = 0; pb_cnt = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 100 && txn < 4; cyc++) begin
      @(negedge clk);
      if (o_sram_request) begin
        if (busy == 0) begin
          if (seen) check("b2b gap", gap, 2);
          if (txn % 2 == 0) begin
            check("b2b A rw", o_sram_rw, 1);
            check("b2b A addr", o_sram_address, 32'h40);
            check("b2b A wdata", o_sram_wdata, 32'hCAFE_F00D);
          end else begin
            check("b2b B rw", o_sram_rw, 0);
            check("b2b B addr", o_sram_address, 32'h80);
          end
        end
        busy++;
        gap = 0;
        i_sram_ready = (busy == 2);
        i_sram_rdata = 32'h1000 + txn;
      end else begin
        i_sram_ready = 1'b0;
        busy = 0;
        gap++;
        if (o_pa_ready || o_pb_ready) begin
          check("b2b order pa", o_pa_ready, txn % 2 == 0);
          check("b2b order pb", o_pb_ready, txn % 2 == 1);
          check("b2b rdata", o_pa_ready ? o_pa_rdata : o_pb_rdata, 32'h1000 + txn);
          if (o_pa_ready) pa_cnt++;
          if (o_pb_ready) pb_cnt++;
          txn++;
          seen = 1'b1;
          if (txn == 4) drop_all();
        end
      end
    end
    check("b2b transactions", txn, 4);
    check("b2b A pulses", pa_cnt, 2);
    check("b2b B pulses", pb_cnt, 2);
    @(negedge clk);
    model_pa_rdata = 32'h1002;
    model_pb_rdata = 32'h1003;

    // Port A address/direction change after grant must not reach the controller.
    i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h10; i_pa_wdata = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("hold req", o_sram_request, 1);
      check("hold addr", o_sram_address, 32'h10);
      check("hold rw", o_sram_rw, 0);
      if (i == 1) begin
        i_pa_address = 32'h20; i_pa_rw = 1'b1; i_pa_wdata = 32'hFFFF_FFFF;
      end
      if (i == 3) begin
        i_sram_ready = 1'b1; i_sram_rdata = 32'h0000_0010;
      end
    end
    @(negedge clk);
    check("hold release req", o_sram_request, 0);
    check("hold pa_ready", o_pa_ready, 1);
    check("hold pa_rdata", o_pa_rdata, 32'h0000_0010);
    check("hold pb_rdata", o_pb_rdata, model_pb_rdata);
    drop_all();
    @(negedge clk);

    // Asynchronous reset mid-transaction: request drops without a clock edge.
    i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h500;
    @(negedge clk);
    check("abort busy req", o_sram_request, 1);
    #2 i_reset_n = 1'b0;
    #1;
    check("abort req drop", o_sram_request, 0);
    check("abort readies", {o_pa_ready, o_pb_ready}, 0);
    check("abort addr", o_sram_address, 0);
    check("abort pa_rdata", o_pa_rdata, 0);
    drop_all();
    repeat (2) begin
      @(negedge clk);
      check("abort no ready", {o_pa_ready, o_pb_ready}, 0);
    end
    i_reset_n = 1'b1;
    model_pa_rdata = '0;
    model_pb_rdata = '0;
    run_vec(fresh, "post-reset");

`ifdef SRAM_ARBITER_TIMEOUT_EN
    // Controller never answers: abort after TIMEOUT busy cycles.
    i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h700;
    busy = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (o_sram_request) busy++;
      else if (busy > 0) done = 1'b1;
    end
    check("timeout busy cycles", busy, 64);
    check("timeout pa_ready", o_pa_ready, 1);
    check("timeout pa_rdata", o_pa_rdata, 32'hDEAD_BEEF);
    check("timeout error", o_error, 1);
    drop_all();
    @(negedge clk);
    run_vec(fresh, "after-timeout");
    check("error sticky", o_error, 1);
`else
    check("error tied low", o_error, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
